gate_exerciser: RTL
===================

GATE_EXERCISER -- requirements
Module: gate_exerciser

Interface
REQ-001 SHALL have parameter NUM_VEC, default 16, meaning vectors per run (legal 1..255).
REQ-002 SHALL have parameter SETTLE, default 2, meaning settle cycles between drive and sample (legal 1..15).
REQ-003 SHALL have parameter SEED, default 8'hA5, meaning LFSR load value (nonzero).
REQ-004 SHALL have parameter INVERT, default 1, meaning expected = ~dut_in when 1, expected = dut_in when 0.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port start  input  1  run request, sampled in IDLE only.
REQ-008 SHALL have port abort  input  1  terminate run in progress.
REQ-009 SHALL have port dut_out  input  1  output of gate under test.
REQ-010 SHALL have port dut_in  output  1  registered stimulus to gate under test.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port done  output  1  run completed; held until next accepted start, abort or rst.
REQ-013 SHALL have port pass  output  1  valid when done=1; 1 iff err_count==0.
REQ-014 SHALL have port err_count  output  8  mismatches in current/last run.
REQ-015 SHALL have port vec_count  output  8  vectors sampled in current/last run.

Function
REQ-016 SHALL implement FSM states IDLE, DRIVE, SETTLE, SAMPLE, DONE; all outputs registered.
REQ-017 SHALL, in IDLE with start=1, clear err_count, vec_count, done, pass, load LFSR with SEED, go to DRIVE.
REQ-018 SHALL, in DRIVE, register dut_in <= lfsr[0], load settle counter with SETTLE-1, go to SETTLE.
REQ-019 SHALL stay in SETTLE for exactly SETTLE cycles (counter decrements to 0), then go to SAMPLE.
REQ-020 SHALL, in SAMPLE, increment err_count when dut_out != expected, increment vec_count, advance LFSR once.
REQ-021 SHALL use 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, shift right, new bit into [7].
REQ-022 SHALL, from SAMPLE, go to DONE when new vec_count == NUM_VEC, else to DRIVE.
REQ-023 SHALL, in DONE, set done=1, pass=(err_count==0), dut_in=0, then go to IDLE.
REQ-024 SHALL hold dut_in constant from DRIVE through SAMPLE of each vector.
REQ-025 SHALL take SETTLE+2 cycles per vector; done SHALL assert NUM_VEC*(SETTLE+2)+1 edges after the edge accepting start.
REQ-026 SHALL ignore start while busy=1.
REQ-027 SHALL, on abort=1 in DRIVE/SETTLE/SAMPLE/DONE, go to IDLE next edge with dut_in=0, done=0, pass=0; counts retain values.
REQ-028 SHALL give abort priority over run progress and over start in the same cycle.
REQ-029 SHALL never exceed 255 on err_count or vec_count (bounded by NUM_VEC<=255; no wrap).
REQ-030 SHALL accept start in IDLE while done=1 (restart clears done at that edge).

Reset
REQ-031 SHALL, with rst=1 at a rising edge, enter IDLE and set dut_in=0, busy=0, done=0, pass=0, err_count=0, vec_count=0, LFSR=SEED.
REQ-032 SHALL give rst priority over abort and start, including mid-run.

Verification
REQ-033 SHALL cover: defaults, dut_out=~dut_in model, start pulse -> done=1 at edge 65, pass=1, err_count=0, vec_count=16.
REQ-034 SHALL cover: defaults, dut_out=dut_in (buffer) -> done at edge 65, pass=0, err_count=16.
REQ-035 SHALL cover: first vector dut_in=1 (SEED[0]) registered one edge after start; second vector value equals LFSR-model bit.
REQ-036 SHALL cover: abort asserted in SETTLE of vector 5 -> busy=0 next edge, done=0, vec_count=4.
REQ-037 SHALL cover: start re-pulsed while busy -> no restart, done still at edge 65; rst mid-run -> all outputs zero next edge.
REQ-038 SHALL cover: NUM_VEC=1, SETTLE=1, ideal inverter -> done at edge 4, vec_count=1, pass=1.

Source files
------------

// File: rtl/gate_exerciser.sv
// Drives LFSR stimulus into a single-bit gate under test, waits a settle period,
// then compares the gate output against the expected (optionally inverted) value.
module gate_exerciser #(
  parameter int unsigned NUM_VEC = 16,
  parameter int unsigned SETTLE  = 2,
  parameter logic [7:0]  SEED    = 8'hA5,
  parameter bit          INVERT  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       dut_out,
  output logic       dut_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [7:0] vec_count
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_lfsr;
  logic [3:0] r_cnt;
  logic       r_dut_in;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [7:0] r_err;
  logic [7:0] r_vec;

  logic [7:0] w_vec_inc;
  logic [7:0] w_lfsr_next;
  logic       w_expected;
  logic       w_mismatch;
  logic       w_abort;

  assign w_vec_inc   = r_vec + 8'd1;
  // Taps x^8,x^6,x^5,x^4 map to bits 0,2,3,4 when shifting right
  assign w_lfsr_next = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[4], r_lfsr[7:1]};
  assign w_expected  = INVERT ? ~r_dut_in : r_dut_in;
  assign w_mismatch  = (dut_out != w_expected);
  assign w_abort     = abort && (r_state != ST_IDLE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next = ST_DRIVE;
      ST_DRIVE:  w_next = ST_SETTLE;
      ST_SETTLE: if (r_cnt == 4'd0) w_next = ST_SAMPLE;
      ST_SAMPLE: w_next = (w_vec_inc == 8'(NUM_VEC)) ? ST_DONE : ST_DRIVE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
    if (w_abort) w_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_lfsr   <= SEED;
      r_cnt    <= '0;
      r_dut_in <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_err    <= '0;
      r_vec    <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != ST_IDLE);
      if (w_abort) begin
        r_dut_in <= 1'b0;
        r_done   <= 1'b0;
        r_pass   <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_err  <= '0;
              r_vec  <= '0;
              r_done <= 1'b0;
              r_pass <= 1'b0;
              r_lfsr <= SEED;
            end
          end
          ST_DRIVE: begin
            r_dut_in <= r_lfsr[0];
            r_cnt    <= 4'(SETTLE - 1);
          end
          ST_SETTLE: begin
            if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
          end
          ST_SAMPLE: begin
            if (w_mismatch && (r_err != 8'hFF)) r_err <= r_err + 8'd1;
            if (r_vec != 8'hFF) r_vec <= w_vec_inc;
            r_lfsr <= w_lfsr_next;
          end
          ST_DONE: begin
            r_done   <= 1'b1;
            r_pass   <= (r_err == 8'd0);
            r_dut_in <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign dut_in    = r_dut_in;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err;
  assign vec_count = r_vec;

endmodule
